// File: rtl/mat_result_collector.sv
// Captures the mat_ops element stream into a local buffer, latches dims/status at op_done and
// replays the held frame row-major over valid/ready. Optional row-end marking: MAT_COLLECT_ROWMARK_EN.
module mat_result_collector #(
    parameter  int DW        = 8,
    parameter  int DIM_W     = 3,
    parameter  int MAX_ELEMS = 25,
    localparam int IW        = $clog2(MAX_ELEMS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             busy_flag,
    input  logic             op_done,
    input  logic [DW-1:0]    result_data,
    input  logic [DIM_W-1:0] result_m,
    input  logic [DIM_W-1:0] result_n,
    input  logic             error_flag,
    input  logic             drain_req,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [DW-1:0]    out_data,
    output logic [IW-1:0]    out_idx,
    output logic             out_last,
    output logic             out_row_end,
    output logic             frame_ready,
    output logic             drain_done,
    output logic [DIM_W-1:0] res_m,
    output logic [DIM_W-1:0] res_n,
    output logic [IW-1:0]    res_count,
    output logic             res_err,
    output logic             size_mismatch,
    output logic             overflow
);

    typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_HOLD, ST_DRAIN} state_t;

    localparam int PW = 2 * DIM_W;
    localparam int CW = (PW > IW) ? PW : IW;
    localparam logic [IW-1:0] MAX_PTR = IW'(MAX_ELEMS);

    logic [DW-1:0] mem_q [MAX_ELEMS];
    logic          mem_we;
    logic [IW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    state_t           state_q, state_d;
    logic [IW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [IW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [DW-1:0]    out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             frame_ready_q, frame_ready_d;
    logic             drain_done_q, drain_done_d;
    logic [DIM_W-1:0] res_m_q, res_m_d;
    logic [DIM_W-1:0] res_n_q, res_n_d;
    logic [IW-1:0]    res_count_q, res_count_d;
    logic             res_err_q, res_err_d;
    logic             size_mismatch_q, size_mismatch_d;
    logic             overflow_q, overflow_d;
    logic             cap;
    logic [PW-1:0]    dim_prod;
`ifdef MAT_COLLECT_ROWMARK_EN
    logic [DIM_W-1:0] col_q, col_d;
    logic             out_row_end_q, out_row_end_d;
`endif

    // A completion pulse is never an element, even if busy is still high.
    assign cap      = busy_flag & ~op_done;
    assign dim_prod = PW'(result_m) * PW'(result_n);

    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        out_valid_d     = out_valid_q;
        out_data_d      = out_data_q;
        out_last_d      = out_last_q;
        frame_ready_d   = frame_ready_q;
        drain_done_d    = 1'b0;
        res_m_d         = res_m_q;
        res_n_d         = res_n_q;
        res_count_d     = res_count_q;
        res_err_d       = res_err_q;
        size_mismatch_d = size_mismatch_q;
        overflow_d      = overflow_q;
        mem_we          = 1'b0;
        mem_waddr       = '0;
        mem_wdata       = result_data;
`ifdef MAT_COLLECT_ROWMARK_EN
        col_d           = col_q;
        out_row_end_d   = out_row_end_q;
`endif
        if (op_done) begin
            res_m_d         = result_m;
            res_n_d         = result_n;
            res_err_d       = error_flag;
            // Only a capture in progress owns wr_ptr; otherwise the frame is empty.
            res_count_d     = (state_q == ST_CAPTURE) ? wr_ptr_q : '0;
            size_mismatch_d = (CW'(res_count_d) != CW'(dim_prod));
            frame_ready_d   = 1'b1;
            out_valid_d     = 1'b0;
            state_d         = ST_HOLD;
        end else if (cap) begin
            if (state_q != ST_CAPTURE) begin
                mem_we        = 1'b1;
                mem_waddr     = '0;
                wr_ptr_d      = IW'(1);
                overflow_d    = 1'b0;
                frame_ready_d = 1'b0;
                out_valid_d   = 1'b0;
                state_d       = ST_CAPTURE;
            end else if (wr_ptr_q == MAX_PTR) begin
                overflow_d = 1'b1;
            end else begin
                mem_we    = 1'b1;
                mem_waddr = wr_ptr_q;
                wr_ptr_d  = wr_ptr_q + IW'(1);
            end
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (drain_req) begin
                        if (res_count_q == '0 || res_err_q) begin
                            drain_done_d = 1'b1;
                        end else begin
                            state_d     = ST_DRAIN;
                            rd_ptr_d    = '0;
                            out_valid_d = 1'b1;
                            out_data_d  = mem_q[0];
                            out_last_d  = (res_count_q == IW'(1));
`ifdef MAT_COLLECT_ROWMARK_EN
                            col_d         = '0;
                            out_row_end_d = (res_n_q != '0) &&
                                            ((res_n_q == DIM_W'(1)) || out_last_d);
`endif
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_valid_q && out_ready) begin
                        rd_ptr_d = rd_ptr_q + IW'(1);
                        if (out_last_q) begin
                            out_valid_d  = 1'b0;
                            out_last_d   = 1'b0;
                            drain_done_d = 1'b1;
                            state_d      = ST_HOLD;
`ifdef MAT_COLLECT_ROWMARK_EN
                            out_row_end_d = 1'b0;
`endif
                        end else begin
                            out_data_d = mem_q[rd_ptr_d];
                            out_last_d = (rd_ptr_d == res_count_q - IW'(1));
`ifdef MAT_COLLECT_ROWMARK_EN
                            col_d         = (col_q == res_n_q - DIM_W'(1)) ? '0 : col_q + DIM_W'(1);
                            out_row_end_d = (res_n_q != '0) &&
                                            ((col_d == res_n_q - DIM_W'(1)) || out_last_d);
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_last_q      <= 1'b0;
            frame_ready_q   <= 1'b0;
            drain_done_q    <= 1'b0;
            res_m_q         <= '0;
            res_n_q         <= '0;
            res_count_q     <= '0;
            res_err_q       <= 1'b0;
            size_mismatch_q <= 1'b0;
            overflow_q      <= 1'b0;
`ifdef MAT_COLLECT_ROWMARK_EN
            col_q           <= '0;
            out_row_end_q   <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            out_valid_q     <= out_valid_d;
            out_data_q      <= out_data_d;
            out_last_q      <= out_last_d;
            frame_ready_q   <= frame_ready_d;
            drain_done_q    <= drain_done_d;
            res_m_q         <= res_m_d;
            res_n_q         <= res_n_d;
            res_count_q     <= res_count_d;
            res_err_q       <= res_err_d;
            size_mismatch_q <= size_mismatch_d;
            overflow_q      <= overflow_d;
`ifdef MAT_COLLECT_ROWMARK_EN
            col_q           <= col_d;
            out_row_end_q   <= out_row_end_d;
`endif
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_idx       = rd_ptr_q;
    assign out_last      = out_last_q;
    assign frame_ready   = frame_ready_q;
    assign drain_done    = drain_done_q;
    assign res_m         = res_m_q;
    assign res_n         = res_n_q;
    assign res_count     = res_count_q;
    assign res_err       = res_err_q;
    assign size_mismatch = size_mismatch_q;
    assign overflow      = overflow_q;
`ifdef MAT_COLLECT_ROWMARK_EN
    assign out_row_end   = out_row_end_q;
`else
    assign out_row_end   = 1'b0;
`endif

endmodule
